// File: rtl/store_aligner_if.sv
// Store path bus: CPU-side store request channel plus memory-side write channel.
// master = store requester / memory model side, slave = the store aligner.
interface store_aligner_if;
  // Both channels use strict valid/ready: a transfer happens on the rising clk
  // edge where valid and ready are both high. A valid source holds its payload
  // until that edge, and ready never depends on the valid of the same channel.
  logic        StReq;
  logic [31:0] StAddr;
  logic [31:0] StData;
  logic [1:0]  StSize;
  logic        StReady;

  logic        MemValid;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        MemReady;

  modport master (
    output StReq, StAddr, StData, StSize, MemReady,
    input  StReady, MemValid, MemAddr, MemWData, MemBE
  );

  modport slave (
    input  StReq, StAddr, StData, StSize, MemReady,
    output StReady, MemValid, MemAddr, MemWData, MemBE
  );
endinterface

// File: rtl/store_aligner.sv
// Aligns sb/sh/sw stores onto a 32-bit memory write port through a 2-entry FIFO.
// Optional macro STORE_ALIGN_EXC_EN enables misaligned-store detection on AlignExc.
module store_aligner (
  input  logic             clk,
  input  logic             reset_n,
  store_aligner_if.slave   bus,
  output logic             AlignExc,
  output logic [1:0]       Count
);

  logic [31:0] addr_q [2];
  logic [31:0] data_q [2];
  logic [3:0]  be_q   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count_q;

  logic [31:0] data_new;
  logic [3:0]  be_new;
  logic        misaligned;
  logic        accept;
  logic        push;
  logic        pop;

  // Lane placement of the right-justified store data.
  always_comb begin
    be_new     = 4'b0000;
    data_new   = 32'h0;
    misaligned = 1'b0;
    case (bus.StSize)
      2'b00: begin
        be_new   = 4'b0001 << bus.StAddr[1:0];
        data_new = {24'h0, bus.StData[7:0]} << {bus.StAddr[1:0], 3'b000};
      end
      2'b01: begin
        if (bus.StAddr[1]) begin
          be_new   = 4'b1100;
          data_new = {bus.StData[15:0], 16'h0};
        end else begin
          be_new   = 4'b0011;
          data_new = {16'h0, bus.StData[15:0]};
        end
      end
      default: begin
        be_new   = 4'b1111;
        data_new = bus.StData;
      end
    endcase
`ifdef STORE_ALIGN_EXC_EN
    misaligned = ((bus.StSize == 2'b01) && bus.StAddr[0])
              || ((bus.StSize == 2'b10) && (bus.StAddr[1:0] != 2'b00))
              || (bus.StSize == 2'b11);
`endif
  end

  assign accept = bus.StReq && bus.StReady;
  assign push   = accept && !misaligned;
  assign pop    = bus.MemValid && bus.MemReady;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= 32'h0;
        data_q[i] <= 32'h0;
        be_q[i]   <= 4'h0;
      end
    end else begin
      // A push never lands in the head slot while it is being presented.
      if (push) begin
        addr_q[wr_ptr] <= {bus.StAddr[31:2], 2'b00};
        data_q[wr_ptr] <= data_new;
        be_q[wr_ptr]   <= be_new;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef STORE_ALIGN_EXC_EN
  logic exc_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= accept && misaligned;
    end
  end
  assign AlignExc = exc_q;
`else
  assign AlignExc = 1'b0;
`endif

  assign Count        = count_q;
  assign bus.StReady  = (count_q != 2'd2);
  assign bus.MemValid = (count_q != 2'd0);
  assign bus.MemAddr  = addr_q[rd_ptr];
  assign bus.MemWData = data_q[rd_ptr];
  assign bus.MemBE    = be_q[rd_ptr];

endmodule
